// File: rtl/fetch_if.sv
// Fetch-stage bundle: redirect/stall controls, instruction-memory port and IF/ID outputs.
// The fetch stage takes the slave modport. The driving environment takes the master modport.
interface fetch_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        imem_valid;
    logic [31:0] pc_out;
    logic [31:0] if_id_instruction;
    logic [31:0] if_id_pcplus4;
    logic        if_id_valid;
    logic [31:0] fetch_count;
    logic        fault;

    modport slave (
        input  stall, branch_taken, branch_target, jump, jump_index,
        input  imem_data, imem_valid,
        output imem_addr, pc_out, if_id_instruction, if_id_pcplus4,
        output if_id_valid, fetch_count, fault
    );

    modport master (
        output stall, branch_taken, branch_target, jump, jump_index,
        output imem_data, imem_valid,
        input  imem_addr, pc_out, if_id_instruction, if_id_pcplus4,
        input  if_id_valid, fetch_count, fault
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, issues fetches and fills the IF/ID register.
// Handles branch/jump redirects, decode stalls, memory wait states and misaligned-target faults.
//
// state | meaning
// RUN   | normal fetch, last fetch completed
// MISS  | memory returned wait, fetch of current PC outstanding
// FAULT | misaligned branch target seen, frozen until reset
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic clk,
    input logic rst,
    fetch_if.slave fif
);
    typedef enum logic [1:0] {RUN, MISS, FAULT} state_t;

    // The low PC bits are forced to zero so a misaligned RESET_PC cannot leak through.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] instr, instr_n;
    logic [31:0] pc4, pc4_n;
    logic        valid, valid_n;
    logic [31:0] count, count_n;
    logic [31:0] pc_inc;

    assign pc_inc = pc + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            pc    <= RESET_PC_ALIGNED;
            instr <= '0;
            pc4   <= '0;
            valid <= 1'b0;
            count <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            instr <= instr_n;
            pc4   <= pc4_n;
            valid <= valid_n;
            count <= count_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        instr_n = instr;
        pc4_n   = pc4;
        valid_n = valid;
        count_n = count;

        if (state == FAULT) begin
            instr_n = '0;
            valid_n = 1'b0;
        end else if (fif.branch_taken) begin
            // A taken branch flushes IF/ID even when the target turns out to be misaligned.
            instr_n = '0;
            valid_n = 1'b0;
            if (fif.branch_target[1:0] != 2'b00) begin
                state_n = FAULT;
            end else begin
                pc_n    = fif.branch_target;
                state_n = RUN;
            end
        end else if (fif.jump) begin
            pc_n    = {pc4[31:28], fif.jump_index, 2'b00};
            instr_n = '0;
            valid_n = 1'b0;
            state_n = RUN;
        end else if (fif.stall) begin
            state_n = state;
        end else if (!fif.imem_valid) begin
            instr_n = '0;
            valid_n = 1'b0;
            state_n = MISS;
        end else begin
            pc_n    = pc_inc;
            instr_n = fif.imem_data;
            pc4_n   = pc_inc;
            valid_n = 1'b1;
            count_n = count + 32'd1;
            state_n = RUN;
        end
    end

    assign fif.imem_addr         = pc;
    assign fif.pc_out            = pc;
    assign fif.if_id_instruction = instr;
    assign fif.if_id_pcplus4     = pc4;
    assign fif.if_id_valid       = valid;
    assign fif.fetch_count       = count;
    assign fif.fault             = (state == FAULT);
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the MIPS pipeline, sitting directly upstream of the decode stage inside `top`. It holds the program counter and drives the instruction-memory address. It accepts branch and jump redirects and stalls from later stages, and delivers the IF/ID pipeline register (instruction, PC+4, valid) to decode. It also detects misaligned redirect targets and parks in a fault state.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset (must be word-aligned).
- `Clk`  in  1  system clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Stall`  in  1  hazard hold from decode: freeze PC and IF/ID.
- `BranchTaken`  in  1  branch resolved taken in EX this cycle.
- `BranchTarget`  in  32  byte address for the taken branch.
- `Jump`  in  1  J/JAL decoded in ID this cycle.
- `JumpIndex`  in  26  instr_index field of the jump.
- `IMemAddr`  out  32  fetch address; combinationally equal to `PCOut`.
- `IMemData`  in  32  instruction word for `IMemAddr`, valid same cycle when `IMemValid`=1.
- `IMemValid`  in  1  memory has data this cycle; 0 = wait.
- `PCOut`  out  32  current fetch PC.
- `IF_ID_Instruction`  out  32  latched instruction to decode.
- `IF_ID_PCPlus4`  out  32  latched PC+4 of that instruction.
- `IF_ID_Valid`  out  1  IF/ID holds a real instruction.
- `FetchCount`  out  32  number of instructions delivered to IF/ID.
- `Fault`  out  1  sticky misaligned-redirect flag.

## Operation
- States: RUN, MISS, FAULT.
- Reset (async) sets: `PCOut`=RESET_PC, `IF_ID_Instruction`=0 (NOP), `IF_ID_PCPlus4`=0, `IF_ID_Valid`=0, `FetchCount`=0, `Fault`=0, state RUN.
- Next-PC priority per edge in RUN/MISS:
  1. BranchTaken.
  2. Jump.
  3. Stall.
  4. Memory wait.
  5. Sequential.
- BranchTaken=1:
  - Target[1:0]≠0: go to FAULT, set `Fault`, PC holds.
  - Otherwise: PC←BranchTarget.
  - In both cases IF/ID is flushed (Instruction=0, Valid=0), overriding Stall and Jump.
- Jump=1 (no branch):
  - PC←{IF_ID_PCPlus4[31:28], JumpIndex, 2'b00}.
  - IF/ID flushed; overrides Stall.
- Stall=1 (no redirect): PC, IF/ID, FetchCount hold; IMemValid ignored.
- IMemValid=0 (no redirect, no stall):
  - PC holds.
  - IF/ID gets bubble (Instruction=0, Valid=0).
  - State→MISS.
- IMemValid=1 (no redirect, no stall):
  - PC←PC+4.
  - IF/ID←{IMemData, PC+4, Valid=1}.
  - FetchCount+1.
  - State→RUN.
- MISS behaves identically to RUN; it exists only to flag an outstanding fetch. A redirect while in MISS abandons the pending fetch and moves to RUN.
- FAULT:
  - PC frozen.
  - IF/ID forced to bubble every cycle.
  - All inputs ignored.
  - Exit only by Reset.
- Arithmetic:
  - PC+4 is modulo 2^32: 32'hFFFF_FFFC → 0.
  - FetchCount wraps 32'hFFFF_FFFF → 0.
  - PC[1:0] is always 00.

## Timing
- Fetch latency: the address is presented in cycle N; the instruction appears on IF_ID_* after edge N.
- Redirect penalty:
  - Branch: exactly one flushed slot; the target address is on `IMemAddr` the cycle after BranchTaken.
  - Jump: same, one flushed slot.
- Control inputs are sampled only on the rising edge. `IMemAddr` is combinational from the PC register, with no extra cycle.
- Reset asserted mid-fetch or mid-stall forces all outputs to their reset values immediately, without waiting for a clock edge. The first fetch from RESET_PC occurs on the first edge after deassertion.
- If BranchTaken and Jump are both asserted, the branch wins and the jump is discarded. The jump is in the wrong path.

## Test plan
- Reset held for 400 ns, then sequential fetch with IMemValid=1 and IMemData=PC|0x2000_0000 → PCOut steps 0, 4, 8, …; IF_ID_PCPlus4 = 4, 8, …; FetchCount increments by 1 per cycle; Valid=1.
- Stall high for 3 cycles at PC=0x10 → PC, IF/ID, FetchCount unchanged for 3 edges; fetch resumes at 0x10.
- BranchTaken with target 0x100 while Stall=1 → next PCOut=0x100, IF/ID=NOP with Valid=0, then instruction at 0x100 delivered.
- Jump with JumpIndex=0x40 and IF_ID_PCPlus4=0x9000_0008 → PCOut=0x9000_0100. A simultaneous BranchTaken to 0x200 instead yields 0x200.
- IMemValid=0 for 2 cycles → state MISS, two bubbles, PC holds. With RESET_PC=32'hFFFF_FFFC, PC then wraps to 0.
- BranchTarget=0x102 → Fault=1 and PC frozen for 10 cycles with bubbles. Asserting Reset mid-cycle clears Fault asynchronously and restores PCOut to RESET_PC.
